cla_sub_seq: RTL and testbench

//  Multi-cycle 32-bit subtractor: computes d = a - b - bi as a + ~b + ~bi,
//  one CLA slice per clock, over NSLICE = DATA_W/SLICE_W cycles.

---
 rtl/cla_sub_pkg.sv | 24 ++
 rtl/cla_slice.sv | 44 ++++
 rtl/cla_sub_seq.sv | 125 ++++++++++++
 tb/tb_cla_sub_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cla_sub_pkg.sv
// Shared definitions for the sequential CLA subtractor.
//   - default operand width and per-cycle slice width
//   - derived slice count and slice-counter width for the defaults
//   - FSM state encoding
//   - helper that sizes the slice counter for any slice count
package cla_sub_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int SLICE_W_DEF = 4;
    localparam int NSLICE      = DATA_W_DEF / SLICE_W_DEF;
    localparam int CNT_W       = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice-counter width; never less than one bit, even for a single slice.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// cla_slice: W-bit carry-lookahead adder slice, purely combinational.
// Ports:
//   x, y   in  [W-1:0]  addends
//   ci     in           carry in
//   s      out [W-1:0]  sum
//   co     out          carry out of the MSB
//   c_msb  out          carry into the MSB (used for signed overflow)
module cla_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    // Each carry is built independently from g/p/ci (no carry feeds another
    // carry signal), so every c[i+1] flattens to its own lookahead term.
    always_comb begin
        logic acc;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            acc = ci;
            for (int j = 0; j <= i; j++) begin
                acc = g[j] | (p[j] & acc);
            end
            c[i+1] = acc;
        end
    end

    assign s     = p ^ c[W-1:0];
    assign co    = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/cla_sub_seq.sv
// cla_sub_seq: multi-cycle subtractor, d = a - b - bi computed as a + ~b + ~bi,
// one SLICE_W-bit CLA slice per clock, least-significant slice first.
// Optional feature macro: CLA_SUB_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk    in               rising-edge clock
//   reset  in               asynchronous active-high reset
//   start  in               request, accepted in IDLE or DONE
//   a, b   in  [DATA_W-1:0] minuend / subtrahend, sampled on accept
//   bi     in               borrow in, sampled on accept
//   d      out [DATA_W-1:0] difference, valid while done, held until next accept
//   bo     out              borrow out (= ~final carry)
//   busy   out              high while RUN
//   done   out              one-cycle result-ready pulse
//   ovf    out              signed overflow (CLA_SUB_OVF_EN only)
//
// state | meaning
// IDLE  | waiting for start, result registers hold last result
// RUN   | one slice per clock, cnt = slice being computed
// DONE  | result valid for this cycle; start here is accepted
module cla_sub_seq
    import cla_sub_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              bi,
    output logic [DATA_W-1:0] d,
    output logic              bo,
    output logic              busy,
    output logic              done
`ifdef CLA_SUB_OVF_EN
    ,
    output logic              ovf
`endif
);

    localparam int N_SLICE = DATA_W / SLICE_W;
    localparam int CW      = cnt_width(N_SLICE);
    localparam logic [CW-1:0] LAST = CW'(N_SLICE - 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   a_sh;
    logic [DATA_W-1:0]   nb_sh;
    logic                carry;
    logic [SLICE_W-1:0]  slice_s;
    logic                slice_co;
`ifdef CLA_SUB_OVF_EN
    logic                slice_c_msb;
`else
    logic                unused_slice_c_msb;
`endif

    // Operands are shifted right each RUN cycle so the slice always reads the
    // low SLICE_W bits instead of going through a wide slice-select mux.
    cla_slice #(.W(SLICE_W)) u_slice (
        .x     (a_sh[SLICE_W-1:0]),
        .y     (nb_sh[SLICE_W-1:0]),
        .ci    (carry),
        .s     (slice_s),
        .co    (slice_co),
`ifdef CLA_SUB_OVF_EN
        .c_msb (slice_c_msb)
`else
        .c_msb (unused_slice_c_msb)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            nb_sh <= '0;
            carry <= 1'b0;
            d     <= '0;
            bo    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef CLA_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        nb_sh <= ~b;
                        carry <= ~bi;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    d[int'(cnt)*SLICE_W +: SLICE_W] <= slice_s;
                    carry <= slice_co;
                    a_sh  <= a_sh >> SLICE_W;
                    nb_sh <= nb_sh >> SLICE_W;
                    if (cnt == LAST) begin
                        bo    <= ~slice_co;
`ifdef CLA_SUB_OVF_EN
                        ovf   <= slice_c_msb ^ slice_co;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_sub_seq.sv
// Directed-vector bench for cla_sub_seq with a result scoreboard: each issued
// operation pushes its hand-computed result, and a monitor pops and compares
// whenever done is seen.
module tb_cla_sub_seq;
    import cla_sub_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic [31:0] d;
    logic        bo;
    logic        busy;
    logic        done;
`ifdef CLA_SUB_OVF_EN
    logic        ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    exp_t exp_q[$];

    cla_sub_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .d     (d),
        .bo    (bo),
        .busy  (busy),
        .done  (done)
`ifdef CLA_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, expv);
        end
    endtask

    // Monitor: compares every presented result with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%h required=no_result", d);
            end else begin
                e = exp_q.pop_front();
                chk("sb_d", d, e.d);
                chk("sb_bo", 32'(bo), 32'(e.bo));
                chk("sb_busy_low", 32'(busy), 32'd0);
`ifdef CLA_SUB_OVF_EN
                chk("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    task automatic push_exp(input logic [31:0] ed, input logic ebo, input logic eovf);
        exp_t e;
        e.d = ed; e.bo = ebo; e.ovf = eovf;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for done after an accepting edge and checks the latency.
    task automatic wait_done(input string name);
        int lat;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(name, 32'(lat), 32'(NSLICE));
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic biv,
                          input logic [31:0] ed, input logic ebo, input logic eovf);
        push_exp(ed, ebo, eovf);
        a = av; b = bv; bi = biv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        @(posedge clk); #1;
        wait_done("latency");
    endtask

    initial begin
        int snap;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d", d, 32'd0);
        chk("rst_flags", {29'd0, bo, busy, done}, 32'd0);
        @(negedge clk) reset = 1'b0;

        // Reset in the middle of RUN, after three slices.
        a = 32'h0000_0000; b = 32'h0000_0001; bi = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("partial_d", d, 32'h0000_0FFF);
        chk("busy_mid_run", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrun_rst_d", d, 32'd0);
        chk("midrun_rst_flags", {29'd0, bo, busy, done}, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(posedge clk); #1;
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op(32'h0000_0003, 32'h0000_0005, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op(32'h0000_1234, 32'h0000_1234, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        @(posedge clk); #1;

        // start held every cycle with changing operands while busy.
        snap = done_cnt;
        push_exp(32'h0000_0FFF, 1'b0, 1'b0);
        a = 32'h0000_1000; b = 32'h0000_0001; bi = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NSLICE; i++) begin
            a = 32'hA5A5_0000 + 32'(i);
            b = 32'h0101_0101 * 32'(i + 2);
            bi = i[0];
            start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_after_ignored_starts", 32'(done), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        chk("single_done", 32'(done_cnt - snap), 32'd1);

        // start on the DONE cycle.
        run_op(32'h48C0_EBA4, 32'h3561_4642, 1'b0, 32'h135F_A562, 1'b0, 1'b0);
        push_exp(32'h0000_000D, 1'b0, 1'b0);
        a = 32'h0000_0010; b = 32'h0000_0003; bi = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("back2back_done_low", 32'(done), 32'd0);
        chk("back2back_busy", 32'(busy), 32'd1);
        chk("back2back_d_held", d, 32'h135F_A562);
        @(posedge clk); #1;
        wait_done("latency_b2b");

        repeat (4) @(posedge clk);
        #1;
        chk("idle_d_held", d, 32'h0000_000D);
        chk("idle_flags", {30'd0, busy, done}, 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
